// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: byte width, sequencer states
// and a small constant helper used to size counters.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PULSE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } tx_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Dual-pointer synchronous byte FIFO with registered flags and drop-on-full.
// Read data is the current head, so a pop and its data land on the same edge.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   wr_drop
);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW:0]            level_q;
  logic [AW:0]            level_d;
  logic                   full_q;
  logic                   empty_q;
  logic                   push;
  logic                   pop;

  // Acceptance looks only at the registered flags, never at the same-cycle pop.
  assign push    = wr_en & ~full_q;
  assign pop     = rd_en & ~empty_q;
  assign wr_drop = wr_en & full_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus pacing sequencer in front of uart_tx: launches one byte per
// trigger pulse, then waits for the frame to start and finish before the next.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  output logic                   tx_timeout,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_int,
  input  logic                   tx_busy
);

  localparam int CNT_MAX = max3(PULSE_CYCLES, START_TIMEOUT, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_int_q, tx_int_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   pop;
  logic [UART_BYTE_W-1:0] fifo_head;
  logic                   fifo_empty;
  logic                   fifo_drop;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level),
    .wr_drop (fifo_drop)
  );

  // One shared counter serves pulse width, start timeout and inter-frame gap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_int_d   = tx_int_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q | fifo_drop;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = fifo_head;
          tx_int_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          tx_int_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WAIT_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_START: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // The launched byte is abandoned rather than retried.
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_int_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_int_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_int_q   <= tx_int_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign empty      = fifo_empty;
  assign overflow   = overflow_q;
  assign tx_timeout = timeout_q;
  assign tx_data    = tx_data_q;
  assign tx_int     = tx_int_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a uart_tx busy model, a launch monitor
// with a byte scoreboard, a table-driven burst and hand-written corner sequences.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       full, empty, overflow, tx_timeout, tx_int;
  logic [4:0] level;
  logic [7:0] tx_data;

  int total = 0;
  int bad = 0;
  int launches = 0;
  int cyc = 0;
  int max_level = 0;
  int busy_mode = 0;      // 0: normal frame model, 1: hold high, 2: hold low
  bit spc_on = 1'b0;
  int spc_prev = -1;
  logic [7:0] sb[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    int         exp_level;
    int         exp_empty;
    int         exp_full;
  } vec_t;
  vec_t vecs[5];

  uart_tx_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .tx_timeout (tx_timeout),
    .tx_data    (tx_data),
    .tx_int     (tx_int),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h) cyc=%0d", name, act, act, exp, exp, cyc);
    end else begin
      $display("ok   %s: %0d cyc=%0d", name, act, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit accepted);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted) sb.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_launch(input int target);
    for (int i = 0; i < 3000 && launches < target; i++) @(negedge clk);
    chk("launch_seen", int'(launches >= target), 1);
  endtask

  // uart_tx model: busy rises 3 cycles after tx_int falls and stays high 100 cycles.
  initial begin
    int cd;
    int bh;
    logic prev;
    cd = 0; bh = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = 0; bh = 0; prev = 1'b0; tx_busy = 1'b0;
      end else if (busy_mode == 1) begin
        tx_busy = 1'b1; cd = 0; bh = 0; prev = tx_int;
      end else if (busy_mode == 2) begin
        tx_busy = 1'b0; cd = 0; bh = 0; prev = tx_int;
      end else begin
        if (bh > 0) begin
          bh--;
          if (bh == 0) tx_busy = 1'b0;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            tx_busy = 1'b1;
            bh = 100;
          end
        end else begin
          tx_busy = 1'b0;
        end
        if (prev && !tx_int) cd = 3;
        prev = tx_int;
      end
    end
  end

  // Launch monitor: pops the scoreboard on each tx_int rise, checks pulse width and spacing.
  initial begin
    logic prev;
    int width;
    prev = 1'b0; width = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev = 1'b0; width = 0;
      end else begin
        if (int'(level) > max_level) max_level = int'(level);
        if (tx_int) width++;
        if (tx_int && !prev) begin
          launches++;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL launch_data: got=0x%0h want=no launch cyc=%0d", tx_data, cyc);
          end else begin
            chk("launch_data", int'(tx_data), int'(sb.pop_front()));
          end
          if (spc_on) begin
            if (spc_prev >= 0) chk("launch_spacing", cyc - spc_prev, 126);
            spc_prev = cyc;
          end
        end
        if (!tx_int && prev) begin
          chk("pulse_width", width, 4);
          width = 0;
        end
        prev = tx_int;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{1'b1, 8'h43, 1, 0, 0};
    vecs[1] = '{1'b1, 8'h43, 2, 0, 0};
    vecs[2] = '{1'b1, 8'h4E, 3, 0, 0};
    vecs[3] = '{1'b1, 8'h55, 4, 0, 0};
    vecs[4] = '{1'b0, 8'h00, 4, 0, 0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_int", int'(tx_int), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_timeout", int'(tx_timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: empty falls one edge after the write, launch one edge later.
    spc_on = 1'b1; spc_prev = -1;
    wr(8'h43, 1'b1);
    chk("s1_empty_after_wr", int'(empty), 0);
    chk("s1_tx_int_lat0", int'(tx_int), 0);
    chk("s1_level_after_wr", int'(level), 1);
    @(negedge clk);
    chk("s1_tx_int_rise", int'(tx_int), 1);
    chk("s1_tx_data", int'(tx_data), 8'h43);
    chk("s1_empty_after_pop", int'(empty), 1);
    repeat (60) @(negedge clk);
    chk("s1_one_launch", launches, 1);

    // CCNU burst written while the first frame is still busy.
    for (int i = 0; i < 5; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].data;
      if (vecs[i].wr_en) sb.push_back(vecs[i].data);
      @(negedge clk);
      chk("tbl_level", int'(level), vecs[i].exp_level);
      chk("tbl_empty", int'(empty), vecs[i].exp_empty);
      chk("tbl_full", int'(full), vecs[i].exp_full);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_launch(2 + k);
      chk("ccnu_level_step", int'(level), 3 - k);
    end
    spc_on = 1'b0;
    repeat (130) @(negedge clk);
    chk("ccnu_empty_end", int'(empty), 1);
    chk("ccnu_sb_drained", sb.size(), 0);

    // Overflow: stall the sequencer, write 18 back-to-back.
    busy_mode = 1;
    base = launches;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      wr(8'h60 + 8'(i), (i < 17));
      if (i == 16) begin
        chk("ovf_full_at_17", int'(full), 1);
        chk("ovf_level_at_17", int'(level), 16);
        chk("ovf_flag_at_17", int'(overflow), 0);
      end
    end
    chk("ovf_flag_at_18", int'(overflow), 1);
    chk("ovf_level_at_18", int'(level), 16);
    repeat (20) @(negedge clk);
    busy_mode = 0;
    wait_launch(base + 17);
    repeat (130) @(negedge clk);
    chk("ovf_empty_end", int'(empty), 1);
    chk("ovf_sb_drained", sb.size(), 0);
    chk("ovf_overflow_sticky", int'(overflow), 1);

    // Start timeout: busy never rises for the first byte.
    busy_mode = 2;
    base = launches;
    wr(8'hA0, 1'b1);
    wr(8'hA1, 1'b1);
    for (int i = 0; i < 20 && tx_int; i++) @(negedge clk);
    chk("to_tx_int_fell", int'(tx_int), 0);
    repeat (1023) @(negedge clk);
    chk("to_not_yet", int'(tx_timeout), 0);
    @(negedge clk);
    chk("to_set", int'(tx_timeout), 1);
    chk("to_launch_count", launches, base + 1);
    repeat (17) @(negedge clk);
    chk("to_gap_no_launch", int'(tx_int), 0);
    @(negedge clk);
    chk("to_next_launch", int'(tx_int), 1);
    busy_mode = 0;
    repeat (200) @(negedge clk);
    chk("to_launch_total", launches, base + 2);
    chk("to_sb_drained", sb.size(), 0);

    // Reset during a pulse with five bytes queued.
    base = launches;
    wr(8'h11, 1'b1);
    wait_launch(base + 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) wr(8'hB0 + 8'(i), 1'b1);
    wait_launch(base + 2);
    chk("rr_level_before", int'(level), 5);
    chk("rr_tx_int_before", int'(tx_int), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_tx_int_async", int'(tx_int), 0);
    chk("rr_level_async", int'(level), 0);
    chk("rr_empty_async", int'(empty), 1);
    chk("rr_tx_data_async", int'(tx_data), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = launches;
    repeat (300) @(negedge clk);
    chk("rr_no_launch", launches, base);
    chk("rr_level_idle", int'(level), 0);
    chk("rr_tx_data_idle", int'(tx_data), 0);
    chk("rr_overflow_clr", int'(overflow), 0);
    chk("rr_timeout_clr", int'(tx_timeout), 0);
    wr(8'h7E, 1'b1);
    wait_launch(base + 1);
    repeat (130) @(negedge clk);
    chk("rr_sb_drained", sb.size(), 0);
    chk("max_level_le16", int'(max_level <= 16), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
